// File: rtl/sha_padder.sv
// SHA-2 message padder: packs 32-bit words into 512/1024-bit blocks,
// appends the 0x80 marker, zero fill and the big-endian bit length.
module sha_padder (
   input  logic          clk,
   input  logic          rstn,
   input  logic          blk_sel,
   input  logic          s_valid,
   input  logic [31:0]   s_data,
   input  logic [2:0]    s_bytes,
   input  logic          s_last,
   output logic          s_ready,
   output logic          valid,
   output logic          new_msg,
   output logic [1023:0] msg,
   input  logic          ready
);

   typedef enum logic [1:0] {FILL, PAD, SEND, LEN} state_t;

   state_t      state_q, state_d;
   logic [4:0]  wcnt_q, wcnt_d;
   logic [63:0] len_q, len_d;
   logic [31:0] words_q [32];
   logic [31:0] words_d [32];
   logic        mode_q, mode_d;
   logic        first_q, first_d;
   logic        nm_pend_q, nm_pend_d;
   logic        extra_q, extra_d;
   logic        final_q, final_d;
   logic        p80_q, p80_d;
   logic [2:0]  lbytes_q, lbytes_d;
   logic        s_ready_q, s_ready_d;
   logic        valid_q, valid_d;
   logic        new_msg_q, new_msg_d;

   logic        mode_w;
   logic [4:0]  last_w;
   logic [4:0]  last_q;
   logic [7:0]  used;
   logic        fit;

   // mode of the word being offered: latched only on a message's first word
   assign mode_w = first_q ? blk_sel : mode_q;
   assign last_w = mode_w ? 5'd31 : 5'd15;
   assign last_q = mode_q ? 5'd31 : 5'd15;
   assign used   = {1'b0, wcnt_q, 2'b00} + {5'd0, lbytes_q} + 8'd1;
   assign fit    = used <= (mode_q ? 8'd112 : 8'd56);

   assign s_ready = s_ready_q;
   assign valid   = valid_q;
   assign new_msg = new_msg_q;

   // word k of the buffer maps to msg[1023-32k -: 32]
   always_comb begin
      msg = '0;
      for (int k = 0; k < 32; k++) begin
         msg[1023-32*k -: 32] = words_q[k];
      end
   end

   // next-state: buffer fill, padding, length insertion and handshakes
   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      len_d     = len_q;
      words_d   = words_q;
      mode_d    = mode_q;
      first_d   = first_q;
      nm_pend_d = nm_pend_q;
      extra_d   = extra_q;
      final_d   = final_q;
      p80_d     = p80_q;
      lbytes_d  = lbytes_q;
      unique case (state_q)
         FILL: begin
            if (s_valid && s_ready_q) begin
               words_d[wcnt_q] = s_data;
               len_d   = len_q + {58'd0, s_bytes, 3'd0};
               mode_d  = mode_w;
               first_d = 1'b0;
               if (s_last) begin
                  state_d  = PAD;
                  lbytes_d = s_bytes;
               end else if (wcnt_q == last_w) begin
                  state_d = SEND;
                  wcnt_d  = 5'd0;
                  final_d = 1'b0;
               end else begin
                  wcnt_d = wcnt_q + 5'd1;
               end
            end
         end
         PAD: begin
            for (int k = 0; k < 32; k++) begin
               if (5'(k) == wcnt_q) begin
                  unique case (lbytes_q)
                     3'd0: words_d[k] = 32'h8000_0000;
                     3'd1: words_d[k] = {words_q[k][31:24], 24'h80_0000};
                     3'd2: words_d[k] = {words_q[k][31:16], 16'h8000};
                     3'd3: words_d[k] = {words_q[k][31:8], 8'h80};
                     default: words_d[k] = words_q[k];
                  endcase
               end else if (5'(k) > wcnt_q) begin
                  if (5'(k) == wcnt_q + 5'd1 && lbytes_q == 3'd4 &&
                      wcnt_q != last_q)
                     words_d[k] = 32'h8000_0000;
                  else
                     words_d[k] = 32'h0;
               end
            end
            if (fit) begin
               if (mode_q) begin
                  words_d[30] = len_q[63:32];
                  words_d[31] = len_q[31:0];
               end else begin
                  words_d[14] = len_q[63:32];
                  words_d[15] = len_q[31:0];
               end
               final_d = 1'b1;
               extra_d = 1'b0;
               p80_d   = 1'b0;
            end else begin
               final_d = 1'b0;
               extra_d = 1'b1;
               // data filled the block exactly: marker opens the extra block
               p80_d   = (lbytes_q == 3'd4) && (wcnt_q == last_q);
            end
            wcnt_d  = 5'd0;
            state_d = SEND;
         end
         SEND: begin
            if (valid_q && ready) begin
               nm_pend_d = 1'b0;
               if (extra_q) begin
                  state_d = LEN;
                  extra_d = 1'b0;
               end else begin
                  state_d = FILL;
                  if (final_q) begin
                     for (int k = 0; k < 32; k++) words_d[k] = 32'h0;
                     len_d     = 64'd0;
                     wcnt_d    = 5'd0;
                     first_d   = 1'b1;
                     nm_pend_d = 1'b1;
                     final_d   = 1'b0;
                  end
               end
            end
         end
         LEN: begin
            for (int k = 0; k < 32; k++) words_d[k] = 32'h0;
            if (p80_q) words_d[0] = 32'h8000_0000;
            if (mode_q) begin
               words_d[30] = len_q[63:32];
               words_d[31] = len_q[31:0];
            end else begin
               words_d[14] = len_q[63:32];
               words_d[15] = len_q[31:0];
            end
            p80_d   = 1'b0;
            final_d = 1'b1;
            state_d = SEND;
         end
         default: state_d = FILL;
      endcase
      s_ready_d = (state_d == FILL);
      valid_d   = (state_d == SEND);
      new_msg_d = (state_d == SEND) ? nm_pend_q : 1'b0;
   end

   // state and registered outputs
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= FILL;
         wcnt_q    <= 5'd0;
         len_q     <= 64'd0;
         for (int k = 0; k < 32; k++) words_q[k] <= 32'h0;
         mode_q    <= 1'b0;
         first_q   <= 1'b1;
         nm_pend_q <= 1'b1;
         extra_q   <= 1'b0;
         final_q   <= 1'b0;
         p80_q     <= 1'b0;
         lbytes_q  <= 3'd0;
         s_ready_q <= 1'b0;
         valid_q   <= 1'b0;
         new_msg_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wcnt_q    <= wcnt_d;
         len_q     <= len_d;
         words_q   <= words_d;
         mode_q    <= mode_d;
         first_q   <= first_d;
         nm_pend_q <= nm_pend_d;
         extra_q   <= extra_d;
         final_q   <= final_d;
         p80_q     <= p80_d;
         lbytes_q  <= lbytes_d;
         s_ready_q <= s_ready_d;
         valid_q   <= valid_d;
         new_msg_q <= new_msg_d;
      end
   end

endmodule

// File: tb/tb_sha_padder.sv
// Bench for sha_padder: byte-level padding model, directed table,
// hand-written latency/reset sequences and randomized messages.
module tb_sha_padder;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          blk_sel = 1'b0;
   logic          s_valid = 1'b0;
   logic [31:0]   s_data = '0;
   logic [2:0]    s_bytes = '0;
   logic          s_last = 1'b0;
   logic          s_ready;
   logic          valid;
   logic          new_msg;
   logic [1023:0] msg;
   logic          ready;

   sha_padder dut (
      .clk(clk), .rstn(rstn), .blk_sel(blk_sel),
      .s_valid(s_valid), .s_data(s_data), .s_bytes(s_bytes),
      .s_last(s_last), .s_ready(s_ready), .valid(valid),
      .new_msg(new_msg), .msg(msg), .ready(ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1023:0] m;
      logic          nm;
   } blk_t;

   typedef struct {
      bit          mode;
      int          n;
      bit          et;
      int          rm;
      int          nblk;
      logic [31:0] w0;
      logic [31:0] wn;
   } vec_t;

   blk_t       got_q[$];
   blk_t       exp_q[$];
   logic [7:0] mb[$];
   int         checks = 0;
   int         errors = 0;
   int         rmode_g = 0;
   int         hold_cnt = 0;

   task automatic chk(input bit ok, input string nm,
                      input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   task automatic cmp_blk(input string nm, input logic [1023:0] a,
                          input logic [1023:0] e);
      logic [1023:0] aa, ee;
      checks++;
      if (a !== e) begin
         errors++;
         for (int k = 0; k < 32; k++) begin
            aa = a << (32*k);
            ee = e << (32*k);
            if (aa[1023:992] !== ee[1023:992]) begin
               $display("FAIL %s word %0d act=%08h exp=%08h",
                        nm, k, aa[1023:992], ee[1023:992]);
               break;
            end
         end
      end
   endtask

   function automatic logic [31:0] wrd(input logic [1023:0] m, input int k);
      logic [1023:0] t;
      t = m << (32*k);
      return t[1023:992];
   endfunction

   // engine side: always, random, hold-10 or never ready
   initial begin
      ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rmode_g)
            0: ready = 1'b1;
            1: ready = ($urandom % 3) != 0;
            2: begin
               if (valid) begin
                  if (hold_cnt >= 10) begin
                     ready = 1'b1;
                     hold_cnt = 0;
                  end else begin
                     ready = 1'b0;
                     hold_cnt++;
                  end
               end else begin
                  ready = 1'b0;
                  hold_cnt = 0;
               end
            end
            default: ready = 1'b0;
         endcase
      end
   end

   // monitor: collect accepted blocks, check stall stability
   logic [1023:0] prev_msg;
   logic          prev_nm;
   bit            prev_stall = 1'b0;
   always @(negedge clk) begin
      if (!rstn) begin
         prev_stall = 1'b0;
      end else begin
         if (valid) chk(!s_ready, "s_ready_in_send", 64'(s_ready), 64'd0);
         if (prev_stall) begin
            chk(valid, "hold_valid", 64'(valid), 64'd1);
            cmp_blk("hold_msg", msg, prev_msg);
            chk(new_msg == prev_nm, "hold_new_msg", 64'(new_msg),
                64'(prev_nm));
         end
         if (valid && ready) got_q.push_back('{msg, new_msg});
         prev_stall = valid && !ready;
         prev_msg = msg;
         prev_nm = new_msg;
      end
   end

   // reference: standard SHA padding of the byte string in mb
   task automatic model_build(input bit mode);
      logic [7:0]   q[$];
      int           bs, ls;
      logic [127:0] bl;
      blk_t         b;
      q = mb;
      bs = mode ? 128 : 64;
      ls = mode ? 16 : 8;
      bl = 128'(mb.size()) * 128'd8;
      q.push_back(8'h80);
      while ((q.size() % bs) != (bs - ls)) q.push_back(8'h00);
      for (int i = ls - 1; i >= 0; i--) q.push_back(bl[8*i +: 8]);
      for (int b0 = 0; b0 < q.size() / bs; b0++) begin
         b.m = '0;
         for (int j = 0; j < bs; j++) b.m[1023-8*j -: 8] = q[b0*bs+j];
         b.nm = (b0 == 0);
         exp_q.push_back(b);
      end
   endtask

   task automatic prep(input bit mode, input int rm);
      got_q.delete();
      exp_q.delete();
      rmode_g = rm;
      model_build(mode);
   endtask

   task automatic send_msg(input bit mode, input bit et, input bit gaps);
      logic [31:0] wd[$];
      logic [2:0]  wb[$];
      logic [31:0] w;
      int          n, i, rem, g;
      n = mb.size();
      i = 0;
      while (i + 4 <= n) begin
         wd.push_back({mb[i], mb[i+1], mb[i+2], mb[i+3]});
         wb.push_back(3'd4);
         i += 4;
      end
      rem = n - i;
      if (rem > 0) begin
         w = $urandom;
         for (int j = 0; j < rem; j++) w[31-8*j -: 8] = mb[i+j];
         wd.push_back(w);
         wb.push_back(3'(rem));
      end else if (n == 0 || et) begin
         wd.push_back($urandom);
         wb.push_back(3'd0);
      end
      for (int k = 0; k < wd.size(); k++) begin
         if (gaps && ($urandom % 3) == 0) begin
            s_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         s_valid = 1'b1;
         s_data  = wd[k];
         s_bytes = wb[k];
         s_last  = (k == wd.size() - 1);
         blk_sel = (k == 0) ? mode : 1'($urandom);
         g = 0;
         while (!s_ready && g < 3000) begin
            @(posedge clk);
            #1;
            g++;
         end
         if (g >= 3000) begin
            chk(1'b0, "s_ready_timeout", 64'(g), 64'd3000);
            break;
         end
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic wait_blocks(input string nm);
      int g;
      g = 0;
      while (!(got_q.size() >= exp_q.size() && s_ready) && g < 3000) begin
         @(posedge clk);
         #1;
         g++;
      end
      chk(g < 3000, {nm, "_timeout"}, 64'(g), 64'd3000);
      repeat (2) @(posedge clk);
      #1;
      chk(got_q.size() == exp_q.size(), {nm, "_nblk"},
          64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         cmp_blk({nm, "_blk"}, got_q[i].m, exp_q[i].m);
         chk(got_q[i].nm == exp_q[i].nm, {nm, "_new_msg"},
             64'(got_q[i].nm), 64'(exp_q[i].nm));
      end
   endtask

   task automatic wait_valid(input string nm);
      int g;
      g = 0;
      while (!valid && g < 500) begin
         @(posedge clk);
         #1;
         g++;
      end
      chk(g < 500, {nm, "_valid_timeout"}, 64'(g), 64'd500);
   endtask

   task automatic fill_pattern(input int n);
      mb.delete();
      for (int i = 0; i < n; i++) mb.push_back(8'(8'h61 + i));
   endtask

   task automatic do_reset(input string nm);
      rstn = 1'b0;
      #1;
      chk(!valid, {nm, "_valid"}, 64'(valid), 64'd0);
      chk(!s_ready, {nm, "_s_ready"}, 64'(s_ready), 64'd0);
      chk(!new_msg, {nm, "_new_msg"}, 64'(new_msg), 64'd0);
      chk(msg == '0, {nm, "_msg"}, 64'(|msg), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      @(posedge clk);
      #1;
      chk(s_ready, {nm, "_s_ready_rel"}, 64'(s_ready), 64'd1);
   endtask

   vec_t tbl[12];

   initial begin
      blk_t lb;
      bit   md;
      tbl[0]  = '{1'b0,   3, 1'b0, 0, 1, 32'h61626380, 32'h018};
      tbl[1]  = '{1'b0,   0, 1'b0, 0, 1, 32'h80000000, 32'h000};
      tbl[2]  = '{1'b0,  56, 1'b0, 0, 2, 32'h00000000, 32'h1C0};
      tbl[3]  = '{1'b1,   3, 1'b0, 0, 1, 32'h61626380, 32'h018};
      tbl[4]  = '{1'b0,  64, 1'b0, 2, 2, 32'h80000000, 32'h200};
      tbl[5]  = '{1'b0,  64, 1'b1, 0, 2, 32'h80000000, 32'h200};
      tbl[6]  = '{1'b0,  55, 1'b0, 1, 1, 32'h61626364, 32'h1B8};
      tbl[7]  = '{1'b1, 112, 1'b0, 1, 2, 32'h00000000, 32'h380};
      tbl[8]  = '{1'b1, 128, 1'b0, 2, 2, 32'h80000000, 32'h400};
      tbl[9]  = '{1'b1, 111, 1'b0, 0, 1, 32'h61626364, 32'h378};
      tbl[10] = '{1'b0,  60, 1'b1, 0, 2, 32'h00000000, 32'h1E0};
      tbl[11] = '{1'b0,  57, 1'b0, 1, 2, 32'h00000000, 32'h1C8};

      do_reset("reset");

      // abc: valid two edges after the last transfer
      fill_pattern(3);
      prep(1'b0, 0);
      send_msg(1'b0, 1'b0, 1'b0);
      chk(!valid, "lat_pad", 64'(valid), 64'd0);
      @(posedge clk);
      #1;
      chk(valid, "lat_valid", 64'(valid), 64'd1);
      chk(new_msg, "lat_new_msg", 64'(new_msg), 64'd1);
      wait_blocks("abc");

      // extra block returns two edges after the previous acceptance
      fill_pattern(56);
      prep(1'b0, 0);
      send_msg(1'b0, 1'b0, 1'b0);
      wait_valid("x56");
      @(posedge clk);
      #1;
      chk(!valid, "extra_gap", 64'(valid), 64'd0);
      @(posedge clk);
      #1;
      chk(valid, "extra_valid", 64'(valid), 64'd1);
      chk(!new_msg, "extra_new_msg", 64'(new_msg), 64'd0);
      wait_blocks("x56");

      // directed table
      foreach (tbl[t]) begin
         fill_pattern(tbl[t].n);
         prep(tbl[t].mode, tbl[t].rm);
         send_msg(tbl[t].mode, tbl[t].et, 1'b0);
         wait_blocks($sformatf("tbl%0d", t));
         chk(got_q.size() == tbl[t].nblk, $sformatf("tbl%0d_count", t),
             64'(got_q.size()), 64'(tbl[t].nblk));
         lb.m = '0;
         lb.nm = 1'b0;
         if (got_q.size() > 0) lb = got_q[got_q.size()-1];
         chk(wrd(lb.m, 0) == tbl[t].w0, $sformatf("tbl%0d_w0", t),
             64'(wrd(lb.m, 0)), 64'(tbl[t].w0));
         chk(wrd(lb.m, tbl[t].mode ? 31 : 15) == tbl[t].wn,
             $sformatf("tbl%0d_wlen", t),
             64'(wrd(lb.m, tbl[t].mode ? 31 : 15)), 64'(tbl[t].wn));
         chk(lb.nm == (tbl[t].nblk == 1), $sformatf("tbl%0d_nm", t),
             64'(lb.nm), 64'(tbl[t].nblk == 1));
      end

      // reset after five words of a message
      fill_pattern(40);
      rmode_g = 0;
      for (int k = 0; k < 5; k++) begin
         s_valid = 1'b1;
         s_data  = {mb[4*k], mb[4*k+1], mb[4*k+2], mb[4*k+3]};
         s_bytes = 3'd4;
         s_last  = 1'b0;
         blk_sel = 1'b0;
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0;
      do_reset("rst_mid");
      fill_pattern(3);
      prep(1'b0, 0);
      send_msg(1'b0, 1'b0, 1'b0);
      wait_blocks("rst_mid_abc");

      // reset while a block waits for the engine
      fill_pattern(64);
      prep(1'b0, 3);
      send_msg(1'b0, 1'b0, 1'b0);
      wait_valid("rst_send");
      do_reset("rst_send");
      fill_pattern(3);
      prep(1'b0, 0);
      send_msg(1'b0, 1'b0, 1'b0);
      wait_blocks("rst_send_abc");

      // randomized messages
      for (int r = 0; r < 30; r++) begin
         int n;
         md = 1'($urandom);
         n = $urandom_range(0, 300);
         mb.delete();
         for (int i = 0; i < n; i++) mb.push_back(8'($urandom));
         prep(md, 1);
         send_msg(md, 1'($urandom), 1'b1);
         wait_blocks($sformatf("rnd%0d", r));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
